// File: rtl/flow_ctrl.sv
// rtl/flow_ctrl.sv - pipeline stall/flush/redirect controller with pending-jump FSM
module flow_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_ready_i,
    input  logic        id_load_use_i,
    input  logic        ex_div_busy_i,
    input  logic        ex_jump_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    output logic        fc_stall_pc_o,
    output logic        fc_stall_ifid_o,
    output logic        fc_stall_idex_o,
    output logic        fc_stall_exmem_o,
    output logic        fc_flush_ifid_o,
    output logic        fc_flush_idex_o,
    output logic        fc_flush_exmem_o,
    output logic        fc_flush_memwb_o,
    output logic        fc_jump_o,
    output logic [31:0] fc_jump_addr_o,
    output logic [31:0] fc_stall_cnt_o
);

    typedef enum logic {IDLE, PEND_JUMP} state_t;

    state_t      state, state_next;
    logic [31:0] pend_addr, pend_addr_next;
    logic [31:0] stall_cnt;
    logic        mem_stall, div_stall;
    logic [3:0]  stall_raw, flush_raw;
    logic        jump_raw;
    logic [31:0] jump_addr_raw;

    assign mem_stall = mem_req_i & ~mem_ready_i;
    assign div_stall = ex_div_busy_i & ~mem_stall;

    // State and latched redirect target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend_addr <= 32'h0;
        end else begin
            state     <= state_next;
            pend_addr <= pend_addr_next;
        end
    end

    // Priority resolution: memory stall > divider stall > redirect > load-use.
    // stall_raw = {pc, ifid, idex, exmem}, flush_raw = {ifid, idex, exmem, memwb}
    always_comb begin
        state_next     = state;
        pend_addr_next = pend_addr;
        stall_raw      = 4'b0000;
        flush_raw      = 4'b0000;
        jump_raw       = 1'b0;
        jump_addr_raw  = 32'h0;
        if (mem_stall) begin
            stall_raw = 4'b1111;
            flush_raw = 4'b0001;
        end else if (div_stall) begin
            stall_raw = 4'b1110;
            flush_raw = 4'b0010;
        end else if (state == IDLE) begin
            if (ex_jump_i && if_ready_i) begin
                jump_raw      = 1'b1;
                jump_addr_raw = ex_jump_addr_i;
                flush_raw     = 4'b1100;
            end else if (ex_jump_i) begin
                // Fetch in flight: hold PC until IF can accept the redirect
                pend_addr_next = ex_jump_addr_i;
                state_next     = PEND_JUMP;
                stall_raw      = 4'b1000;
                flush_raw      = 4'b0100;
            end else if (id_load_use_i) begin
                stall_raw = 4'b1100;
                flush_raw = 4'b0100;
            end
        end else begin
            if (if_ready_i) begin
                // Stale fetch in IF/ID is discarded as the redirect goes out
                jump_raw      = 1'b1;
                jump_addr_raw = pend_addr;
                flush_raw     = 4'b1000;
                state_next    = IDLE;
            end else begin
                stall_raw = 4'b1000;
                flush_raw = 4'b0100;
            end
        end
    end

    // Outputs are held quiet while reset is asserted
    always_comb begin
        {fc_stall_pc_o, fc_stall_ifid_o, fc_stall_idex_o, fc_stall_exmem_o} = rst_n ? stall_raw : 4'b0000;
        {fc_flush_ifid_o, fc_flush_idex_o, fc_flush_exmem_o, fc_flush_memwb_o} = rst_n ? flush_raw : 4'b0000;
        fc_jump_o      = rst_n & jump_raw;
        fc_jump_addr_o = rst_n ? jump_addr_raw : 32'h0;
    end

    // Count cycles in which the PC is held; wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'h0;
        end else if (fc_stall_pc_o) begin
            stall_cnt <= stall_cnt + 32'h1;
        end
    end

    assign fc_stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_flow_ctrl.sv
// tb/tb_flow_ctrl.sv - directed self-checking bench for flow_ctrl
module tb_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_ready, id_load_use, ex_div_busy, ex_jump, mem_req, mem_ready;
    logic [31:0] ex_jump_addr;
    logic        s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, f_exmem, f_memwb, jump;
    logic [31:0] jump_addr, stall_cnt;
    logic [3:0]  stall, flush;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign stall = {s_pc, s_ifid, s_idex, s_exmem};
    assign flush = {f_ifid, f_idex, f_exmem, f_memwb};

    flow_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .if_ready_i(if_ready), .id_load_use_i(id_load_use), .ex_div_busy_i(ex_div_busy),
        .ex_jump_i(ex_jump), .ex_jump_addr_i(ex_jump_addr),
        .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .fc_stall_pc_o(s_pc), .fc_stall_ifid_o(s_ifid), .fc_stall_idex_o(s_idex), .fc_stall_exmem_o(s_exmem),
        .fc_flush_ifid_o(f_ifid), .fc_flush_idex_o(f_idex), .fc_flush_exmem_o(f_exmem), .fc_flush_memwb_o(f_memwb),
        .fc_jump_o(jump), .fc_jump_addr_o(jump_addr), .fc_stall_cnt_o(stall_cnt)
    );

    // Advance to the next falling edge, apply one input vector, let logic settle
    task automatic step(input logic rdy, input logic lu, input logic div, input logic jmp,
                        input logic [31:0] addr, input logic mreq, input logic mrdy);
        @(negedge clk);
        if_ready = rdy; id_load_use = lu; ex_div_busy = div; ex_jump = jmp;
        ex_jump_addr = addr; mem_req = mreq; mem_ready = mrdy;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(1, 1, 1, 1, 32'h123, 1, 0);
        checks++; if (stall !== 4'b0000) begin failures++; $display("FAIL rst_stall got=%b exp=0000", stall); end
        checks++; if (flush !== 4'b0000) begin failures++; $display("FAIL rst_flush got=%b exp=0000", flush); end
        checks++; if (jump !== 1'b0 || jump_addr !== 32'h0) begin failures++; $display("FAIL rst_jump got=%b/%h exp=0/0", jump, jump_addr); end
        checks++; if (stall_cnt !== 32'h0) begin failures++; $display("FAIL rst_cnt got=%h exp=0", stall_cnt); end
        step(0, 0, 0, 0, 32'h0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use;
        step(0, 1, 0, 0, 32'h0, 0, 0);
        checks++; if (stall !== 4'b1100) begin failures++; $display("FAIL lu_stall got=%b exp=1100", stall); end
        checks++; if (flush !== 4'b0100) begin failures++; $display("FAIL lu_flush got=%b exp=0100", flush); end
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL lu_cnt0 got=%0d exp=0", stall_cnt); end
        step(0, 0, 0, 0, 32'h0, 0, 0);
        checks++; if (stall_cnt !== 32'd1) begin failures++; $display("FAIL lu_cnt1 got=%0d exp=1", stall_cnt); end
        checks++; if (stall !== 4'b0000 || flush !== 4'b0000) begin failures++; $display("FAIL lu_idle got=%b/%b exp=0000/0000", stall, flush); end
    endtask

    task automatic test_jump_ready;
        step(1, 0, 0, 1, 32'h100, 0, 0);
        checks++; if (jump !== 1'b1 || jump_addr !== 32'h100) begin failures++; $display("FAIL jr_jump got=%b/%h exp=1/100", jump, jump_addr); end
        checks++; if (flush !== 4'b1100 || stall !== 4'b0000) begin failures++; $display("FAIL jr_sf got=%b/%b exp=0000/1100", stall, flush); end
        step(1, 0, 0, 0, 32'h100, 0, 0);
        checks++; if (jump !== 1'b0 || jump_addr !== 32'h0) begin failures++; $display("FAIL jr_after got=%b/%h exp=0/0", jump, jump_addr); end
    endtask

    task automatic test_jump_miss;
        // Load-use in the same cycle as the accepted jump must lose
        step(0, 1, 0, 1, 32'h200, 0, 0);
        checks++; if (stall !== 4'b1000 || flush !== 4'b0100) begin failures++; $display("FAIL jm_c1 got=%b/%b exp=1000/0100", stall, flush); end
        checks++; if (jump !== 1'b0 || jump_addr !== 32'h0) begin failures++; $display("FAIL jm_c1_jump got=%b/%h exp=0/0", jump, jump_addr); end
        for (int i = 2; i <= 3; i++) begin
            step(0, 1, 0, 1, 32'h999, 0, 0);
            checks++; if (stall !== 4'b1000 || flush !== 4'b0100 || jump !== 1'b0) begin
                failures++; $display("FAIL jm_c%0d got=%b/%b/%b exp=1000/0100/0", i, stall, flush, jump); end
        end
        step(1, 1, 0, 1, 32'h999, 0, 0);
        checks++; if (jump !== 1'b1 || jump_addr !== 32'h200) begin failures++; $display("FAIL jm_c4_jump got=%b/%h exp=1/200", jump, jump_addr); end
        checks++; if (flush !== 4'b1000 || stall !== 4'b0000) begin failures++; $display("FAIL jm_c4_sf got=%b/%b exp=0000/1000", stall, flush); end
        step(1, 0, 0, 0, 32'h0, 0, 0);
        checks++; if (jump !== 1'b0 || stall !== 4'b0000 || flush !== 4'b0000) begin failures++; $display("FAIL jm_idle got=%b/%b/%b exp=0/0000/0000", jump, stall, flush); end
        checks++; if (stall_cnt !== 32'd4) begin failures++; $display("FAIL jm_cnt got=%0d exp=4", stall_cnt); end
    endtask

    task automatic test_priority;
        step(1, 1, 1, 1, 32'h300, 1, 0);
        checks++; if (stall !== 4'b1111 || flush !== 4'b0001 || jump !== 1'b0) begin failures++; $display("FAIL pr_mem got=%b/%b/%b exp=1111/0001/0", stall, flush, jump); end
        step(1, 1, 1, 1, 32'h300, 1, 1);
        checks++; if (stall !== 4'b1110 || flush !== 4'b0010 || jump !== 1'b0) begin failures++; $display("FAIL pr_div got=%b/%b/%b exp=1110/0010/0", stall, flush, jump); end
        step(1, 0, 0, 1, 32'h300, 1, 1);
        checks++; if (jump !== 1'b1 || jump_addr !== 32'h300 || flush !== 4'b1100) begin failures++; $display("FAIL pr_jump got=%b/%h/%b exp=1/300/1100", jump, jump_addr, flush); end
        step(0, 0, 0, 0, 32'h0, 0, 0);
        checks++; if (stall_cnt !== 32'd6) begin failures++; $display("FAIL pr_cnt got=%0d exp=6", stall_cnt); end
    endtask

    task automatic test_pend_hazard;
        step(0, 0, 0, 1, 32'h0000_0abc, 0, 0);
        step(1, 0, 1, 0, 32'h0, 0, 0);
        checks++; if (stall !== 4'b1110 || flush !== 4'b0010 || jump !== 1'b0) begin failures++; $display("FAIL ph_div got=%b/%b/%b exp=1110/0010/0", stall, flush, jump); end
        step(1, 0, 0, 0, 32'h0, 1, 0);
        checks++; if (stall !== 4'b1111 || flush !== 4'b0001 || jump !== 1'b0) begin failures++; $display("FAIL ph_mem got=%b/%b/%b exp=1111/0001/0", stall, flush, jump); end
        step(1, 0, 0, 0, 32'h0, 0, 0);
        checks++; if (jump !== 1'b1 || jump_addr !== 32'habc || flush !== 4'b1000) begin failures++; $display("FAIL ph_jump got=%b/%h/%b exp=1/abc/1000", jump, jump_addr, flush); end
        step(0, 0, 0, 0, 32'h0, 0, 0);
        checks++; if (stall_cnt !== 32'd9) begin failures++; $display("FAIL ph_cnt got=%0d exp=9", stall_cnt); end
    endtask

    task automatic test_reset_pend;
        step(0, 0, 0, 1, 32'h400, 0, 0);
        @(negedge clk);
        rst_n = 1'b0; ex_jump = 1'b0;
        #1;
        checks++; if (stall !== 4'b0000 || flush !== 4'b0000 || jump !== 1'b0) begin failures++; $display("FAIL rp_outs got=%b/%b/%b exp=0000/0000/0", stall, flush, jump); end
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL rp_cnt got=%0d exp=0", stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0, 32'h0, 0, 0);
        checks++; if (jump !== 1'b0 || jump_addr !== 32'h0 || stall !== 4'b0000) begin failures++; $display("FAIL rp_release got=%b/%h/%b exp=0/0/0000", jump, jump_addr, stall); end
    endtask

    task automatic test_wrap;
        step(0, 0, 0, 0, 32'h0, 0, 0);
        force dut.stall_cnt = 32'hFFFF_FFFF;
        step(0, 0, 0, 0, 32'h0, 0, 0);
        checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wr_pre got=%h exp=ffffffff", stall_cnt); end
        release dut.stall_cnt;
        step(0, 1, 0, 0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 32'h0, 0, 0);
        checks++; if (stall_cnt !== 32'h0) begin failures++; $display("FAIL wr_wrap got=%h exp=00000000", stall_cnt); end
    endtask

    initial begin
        if_ready = 0; id_load_use = 0; ex_div_busy = 0; ex_jump = 0;
        ex_jump_addr = 32'h0; mem_req = 0; mem_ready = 0; rst_n = 1'b0;
        test_reset;
        test_load_use;
        test_jump_ready;
        test_jump_miss;
        test_priority;
        test_pend_hazard;
        test_reset_pend;
        test_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
